// File: rtl/exp_out_credit_buf_pkg.sv
// Shared constants for the FP16 exp path and its result buffer.
package exp_out_credit_buf_pkg;

  localparam int unsigned EXP_DW  = 16;
  localparam logic [15:0] H_ZERO  = 16'h0000;
  localparam logic [15:0] H_ONE   = 16'h3C00;
  localparam logic [15:0] H_LOG2E = 16'h3DC5;
  // Total exp pipeline latency; issuers use it to align side-band data with results.
  localparam int unsigned EXP_LAT = 6;

endpackage

// File: rtl/exp_out_credit_buf_if.sv
// Downstream valid/ready result stream with a group-last marker.
interface exp_out_credit_buf_if
  import exp_out_credit_buf_pkg::*;
#(
  parameter int unsigned DW = EXP_DW
);
  logic          valid;
  logic [DW-1:0] data;
  logic          last;
  logic          ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/exp_out_credit_buf_fwft_fifo.sv
// First-word fall-through FIFO; full/empty come from the occupancy count, not pointer compare.
module exp_out_credit_buf_fwft_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_level;
  logic [CW-1:0] w_level_nxt;
  logic          w_push_acc;

  assign o_full  = (r_level == CW'(DEPTH));
  assign o_empty = (r_level == '0);
  // A pop in the same cycle frees the head slot, so a push while full is still accepted.
  assign w_push_acc = i_push & (~o_full | i_pop);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_acc, i_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/exp_out_credit_buf.sv
// Credit-managed result buffer behind the stall-free FP16 exp pipeline.
module exp_out_credit_buf
  import exp_out_credit_buf_pkg::*;
#(
  parameter int unsigned DW    = EXP_DW,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned GROUP = 8,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_req_i,
  output logic                   issue_ok_o,
  input  logic                   exp_valid_i,
  input  logic [DW-1:0]          exp_y_i,
  exp_out_credit_buf_if.master   m,
  output logic [CW-1:0]          level_o,
  output logic [CW-1:0]          inflight_o,
  output logic                   err_ovf_o,
  output logic                   err_unexp_o
);

  localparam int unsigned GW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GROUP - 1);

  logic [CW-1:0] w_level;
  logic          w_full;
  logic          w_empty;
  logic [CW:0]   w_claimed;
  logic          w_issue;
  logic          w_pop;
  logic          w_dec;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] w_inflight_nxt;
  logic [GW-1:0] r_gcnt;
  logic [GW-1:0] w_gcnt_nxt;
  logic          r_err_ovf;
  logic          r_err_unexp;

  exp_out_credit_buf_fwft_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (exp_valid_i),
    .i_pop   (w_pop),
    .i_data  (exp_y_i),
    .o_data  (m.data),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Slots already holding data or promised to in-flight results are not grantable.
  assign w_claimed  = {1'b0, w_level} + {1'b0, r_inflight};
  assign issue_ok_o = (w_claimed < (CW + 1)'(DEPTH));
  assign w_issue    = issue_req_i & issue_ok_o;
  assign w_pop      = ~w_empty & m.ready;
  assign w_dec      = exp_valid_i & (r_inflight != '0);

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_issue, w_dec})
      2'b10:   w_inflight_nxt = r_inflight + 1'b1;
      2'b01:   w_inflight_nxt = r_inflight - 1'b1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_comb begin
    w_gcnt_nxt = r_gcnt;
    if (w_pop) w_gcnt_nxt = (r_gcnt == GLAST) ? '0 : r_gcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight  <= '0;
      r_gcnt      <= '0;
      r_err_ovf   <= 1'b0;
      r_err_unexp <= 1'b0;
    end else begin
      r_inflight  <= w_inflight_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_err_ovf   <= r_err_ovf | (exp_valid_i & w_full & ~w_pop);
      r_err_unexp <= r_err_unexp | (exp_valid_i & (r_inflight == '0));
    end
  end

  assign m.valid     = ~w_empty;
  assign m.last      = ~w_empty & (r_gcnt == GLAST);
  assign level_o     = w_level;
  assign inflight_o  = r_inflight;
  assign err_ovf_o   = r_err_ovf;
  assign err_unexp_o = r_err_unexp;

endmodule
